// File: rtl/reg_file_pkg.sv
// Shared definitions for the register file with busy-bit scoreboard.
// Holds default geometry, the register count and the byte-strobe merge helper.
package reg_file_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned NUM_REGS   = 2 ** ADDR_W_DEF;

    // The merge helper works on the widest supported register; callers
    // zero-extend their operands and truncate the result back to DATA_W.
    localparam int unsigned MAX_DATA_W = 256;
    localparam int unsigned MAX_STRB_W = MAX_DATA_W / 8;

    // Replace each byte of old_val whose strobe bit is set with the matching
    // byte of new_val.
    function automatic logic [MAX_DATA_W-1:0] merge_bytes(
        input logic [MAX_DATA_W-1:0] old_val,
        input logic [MAX_DATA_W-1:0] new_val,
        input logic [MAX_STRB_W-1:0] strb
    );
        logic [MAX_DATA_W-1:0] result;
        result = old_val;
        for (int unsigned b = 0; b < MAX_STRB_W; b++) begin
            if (strb[b]) begin
                result[b*8 +: 8] = new_val[b*8 +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard for the register file.
// Ports:
//   CLK, RST    clock, asynchronous active-high reset
//   IssueEn     mark IssueAddr busy (new producer issued)
//   IssueAddr   destination being issued
//   ClrEn       clear ClrAddr (writeback)
//   ClrAddr     register being written back
//   RdAddr      packed read addresses, one per read port
//   RdBusy      per-port busy bit of the addressed register (registered state)
//   PendingCnt  number of registers currently busy
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned NUM_RD = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     IssueEn,
    input  logic [ADDR_W-1:0]        IssueAddr,
    input  logic                     ClrEn,
    input  logic [ADDR_W-1:0]        ClrAddr,
    input  logic [NUM_RD*ADDR_W-1:0] RdAddr,
    output logic [NUM_RD-1:0]        RdBusy,
    output logic [ADDR_W:0]          PendingCnt
);

    localparam int unsigned NUM_R = 2 ** ADDR_W;

    logic [NUM_R-1:0] busy_q;
    logic [NUM_R-1:0] busy_d;
    logic [NUM_R-1:0] set_mask;
    logic [NUM_R-1:0] clr_mask;
    logic             cnt_up;
    logic             cnt_down;
    logic [ADDR_W:0]  cnt_q;
    logic [ADDR_W:0]  cnt_d;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (IssueEn) begin
            set_mask[IssueAddr] = 1'b1;
        end
        if (ClrEn) begin
            clr_mask[ClrAddr] = 1'b1;
        end
        // r0 is never a producer target.
        set_mask[0] = 1'b0;
        clr_mask[0] = 1'b0;

        // Issue wins over a simultaneous writeback: it is a newer producer.
        busy_d = set_mask | (busy_q & ~clr_mask);

        // At most one set and one clear per cycle, so each direction moves
        // the count by at most one.
        cnt_up   = |(busy_d & ~busy_q);
        cnt_down = |(busy_q & ~busy_d);
        cnt_d    = cnt_q + {{ADDR_W{1'b0}}, cnt_up} - {{ADDR_W{1'b0}}, cnt_down};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        RdBusy = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            RdBusy[k] = busy_q[RdAddr[k*ADDR_W +: ADDR_W]];
        end
    end

    assign PendingCnt = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with byte strobes, optional write-to-read bypass
// and a busy-bit scoreboard. Register 0 reads as zero and is never busy.
// Ports:
//   CLK, RST    clock, asynchronous active-high reset
//   RdAddr      packed read addresses (port k at [k*ADDR_W +: ADDR_W])
//   RdData      packed combinational read data (port k at [k*DATA_W +: DATA_W])
//   RdBusy      per-port busy flag of the addressed register
//   RegWre      write enable; also clears the destination's busy bit
//   WrAddr      write address
//   WrData      write data
//   WrStrb      byte strobes, bit b enables byte b
//   IssueEn     mark IssueAddr busy
//   IssueAddr   destination being issued
//   PendingCnt  number of busy registers
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned BYPASS = 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_RD*ADDR_W-1:0] RdAddr,
    output logic [NUM_RD*DATA_W-1:0] RdData,
    output logic [NUM_RD-1:0]        RdBusy,
    input  logic                     RegWre,
    input  logic [ADDR_W-1:0]        WrAddr,
    input  logic [DATA_W-1:0]        WrData,
    input  logic [DATA_W/8-1:0]      WrStrb,
    input  logic                     IssueEn,
    input  logic [ADDR_W-1:0]        IssueAddr,
    output logic [ADDR_W:0]          PendingCnt
);

    localparam int unsigned NUM_R = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NUM_R];
    logic [DATA_W-1:0] wr_merged;
    logic              wr_hit;

    // Stored value of the write target with the strobed bytes replaced; used
    // both as the next stored value and as the bypass value.
    assign wr_merged = DATA_W'(merge_bytes(MAX_DATA_W'(regs_q[WrAddr]),
                                           MAX_DATA_W'(WrData),
                                           MAX_STRB_W'(WrStrb)));
    assign wr_hit    = RegWre && (WrAddr != '0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < int'(NUM_R); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_hit) begin
            regs_q[WrAddr] <= wr_merged;
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] addr;
        RdData = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            addr = RdAddr[k*ADDR_W +: ADDR_W];
            if (addr == '0) begin
                RdData[k*DATA_W +: DATA_W] = '0;
            end else if ((BYPASS != 0) && wr_hit && (WrAddr == addr)) begin
                RdData[k*DATA_W +: DATA_W] = wr_merged;
            end else begin
                RdData[k*DATA_W +: DATA_W] = regs_q[addr];
            end
        end
    end

    reg_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) u_scoreboard (
        .CLK        (CLK),
        .RST        (RST),
        .IssueEn    (IssueEn),
        .IssueAddr  (IssueAddr),
        .ClrEn      (RegWre),
        .ClrAddr    (WrAddr),
        .RdAddr     (RdAddr),
        .RdBusy     (RdBusy),
        .PendingCnt (PendingCnt)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: one instance with bypass, one without,
// sharing all inputs.
module tb_reg_file_sb;

    logic        clk;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [63:0] rd_data_nb;
    logic [1:0]  rd_busy;
    logic [1:0]  rd_busy_nb;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        issue_en;
    logic [4:0]  issue_addr;
    logic [5:0]  pend_cnt;
    logic [5:0]  pend_cnt_nb;

    int checks;
    int failures;

    reg_file_sb #(
        .DATA_W (32),
        .ADDR_W (5),
        .NUM_RD (2),
        .BYPASS (1)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .RdAddr     (rd_addr),
        .RdData     (rd_data),
        .RdBusy     (rd_busy),
        .RegWre     (wr_en),
        .WrAddr     (wr_addr),
        .WrData     (wr_data),
        .WrStrb     (wr_strb),
        .IssueEn    (issue_en),
        .IssueAddr  (issue_addr),
        .PendingCnt (pend_cnt)
    );

    reg_file_sb #(
        .DATA_W (32),
        .ADDR_W (5),
        .NUM_RD (2),
        .BYPASS (0)
    ) dut_nb (
        .CLK        (clk),
        .RST        (rst),
        .RdAddr     (rd_addr),
        .RdData     (rd_data_nb),
        .RdBusy     (rd_busy_nb),
        .RegWre     (wr_en),
        .WrAddr     (wr_addr),
        .WrData     (wr_data),
        .WrStrb     (wr_strb),
        .IssueEn    (issue_en),
        .IssueAddr  (issue_addr),
        .PendingCnt (pend_cnt_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int port, input logic [4:0] addr);
        rd_addr[port*5 +: 5] = addr;
    endtask

    task automatic drive_wr(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        wr_strb = strb;
    endtask

    task automatic drive_issue(input logic [4:0] addr);
        issue_en   = 1'b1;
        issue_addr = addr;
    endtask

    task automatic idle();
        wr_en    = 1'b0;
        issue_en = 1'b0;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        rd_addr    = '0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        wr_strb    = '0;
        issue_en   = 1'b0;
        issue_addr = '0;
        #12;
        rst = 1'b0;
        #1;
        check_eq("reset_cnt", 32'(pend_cnt), 32'd0);
        check_eq("reset_busy", 32'(rd_busy), 32'd0);

        // Write r5 and issue it, then reset mid-cycle.
        drive_wr(5'd5, 32'hDEADBEEF, 4'hF);
        drive_issue(5'd5);
        tick();
        idle();
        set_rd(0, 5'd5);
        #1;
        check_eq("r5_written", rd_data[31:0], 32'hDEADBEEF);
        check_eq("r5_busy", 32'(rd_busy[0]), 32'd1);
        check_eq("r5_cnt", 32'(pend_cnt), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst_data", rd_data[31:0], 32'd0);
        check_eq("async_rst_busy", 32'(rd_busy[0]), 32'd0);
        check_eq("async_rst_cnt", 32'(pend_cnt), 32'd0);
        #1;
        rst = 1'b0;

        // Byte strobes.
        drive_wr(5'd3, 32'h11223344, 4'hF);
        tick();
        drive_wr(5'd3, 32'hAABBCCDD, 4'b0101);
        tick();
        idle();
        set_rd(0, 5'd3);
        #1;
        check_eq("strb_merge", rd_data[31:0], 32'h11BB33DD);
        check_eq("strb_merge_nb", rd_data_nb[31:0], 32'h11BB33DD);
        drive_wr(5'd0, 32'hFFFFFFFF, 4'hF);
        set_rd(1, 5'd0);
        #1;
        check_eq("r0_bypass_zero", rd_data[63:32], 32'd0);
        tick();
        idle();
        #1;
        check_eq("r0_after_write", rd_data[63:32], 32'd0);
        check_eq("r0_after_write_nb", rd_data_nb[63:32], 32'd0);

        // Bypass versus stored value.
        drive_wr(5'd7, 32'hCAFEF00D, 4'hF);
        tick();
        set_rd(0, 5'd7);
        drive_wr(5'd7, 32'h12345678, 4'hF);
        #1;
        check_eq("bypass_full", rd_data[31:0], 32'h12345678);
        check_eq("nobypass_old", rd_data_nb[31:0], 32'hCAFEF00D);
        tick();
        idle();
        #1;
        check_eq("nobypass_next", rd_data_nb[31:0], 32'h12345678);
        drive_wr(5'd7, 32'hAAAAAAAA, 4'b0011);
        set_rd(1, 5'd7);
        #1;
        check_eq("bypass_partial", rd_data[63:32], 32'h1234AAAA);
        check_eq("nobypass_partial_old", rd_data_nb[63:32], 32'h12345678);
        tick();
        idle();
        #1;
        check_eq("nobypass_partial_next", rd_data_nb[63:32], 32'h1234AAAA);

        // Scoreboard: issue r4 then r9.
        set_rd(0, 5'd4);
        drive_issue(5'd4);
        #1;
        check_eq("busy_not_bypassed", 32'(rd_busy[0]), 32'd0);
        tick();
        check_eq("issue_r4_cnt", 32'(pend_cnt), 32'd1);
        check_eq("issue_r4_busy", 32'(rd_busy[0]), 32'd1);
        drive_issue(5'd9);
        tick();
        idle();
        #1;
        check_eq("issue_r9_cnt", 32'(pend_cnt), 32'd2);
        drive_wr(5'd4, 32'h00000044, 4'hF);
        tick();
        idle();
        #1;
        check_eq("wb_r4_cnt", 32'(pend_cnt), 32'd1);
        check_eq("wb_r4_busy", 32'(rd_busy[0]), 32'd0);
        check_eq("wb_r4_data", rd_data[31:0], 32'h00000044);

        // Issue and writeback of r9 together: issue wins.
        set_rd(1, 5'd9);
        drive_issue(5'd9);
        drive_wr(5'd9, 32'hFFFFFFFF, 4'h0);
        tick();
        idle();
        #1;
        check_eq("issue_wins_busy", 32'(rd_busy[1]), 32'd1);
        check_eq("issue_wins_cnt", 32'(pend_cnt), 32'd1);
        check_eq("zero_strb_data", rd_data[63:32], 32'd0);

        // Issue r2 while r9 writes back.
        set_rd(0, 5'd2);
        drive_issue(5'd2);
        drive_wr(5'd9, 32'h00000099, 4'hF);
        tick();
        idle();
        #1;
        check_eq("conc_r2_busy", 32'(rd_busy[0]), 32'd1);
        check_eq("conc_r9_clear", 32'(rd_busy[1]), 32'd0);
        check_eq("conc_cnt", 32'(pend_cnt), 32'd1);
        check_eq("conc_r9_data", rd_data[63:32], 32'h00000099);
        set_rd(1, 5'd0);
        drive_issue(5'd0);
        tick();
        idle();
        #1;
        check_eq("issue_r0_cnt", 32'(pend_cnt), 32'd1);
        check_eq("issue_r0_busy", 32'(rd_busy[1]), 32'd0);
        drive_wr(5'd2, 32'h0, 4'h0);
        tick();
        idle();
        #1;
        check_eq("clear_r2_cnt", 32'(pend_cnt), 32'd0);
        check_eq("clear_r2_busy", 32'(rd_busy[0]), 32'd0);

        // Fill every register, then drain.
        for (int r = 1; r < 32; r++) begin
            drive_issue(5'(r));
            tick();
        end
        idle();
        set_rd(0, 5'd31);
        #1;
        check_eq("fill_cnt", 32'(pend_cnt), 32'd31);
        check_eq("fill_cnt_nb", 32'(pend_cnt_nb), 32'd31);
        check_eq("fill_r31_busy", 32'(rd_busy[0]), 32'd1);
        for (int r = 1; r < 32; r++) begin
            drive_wr(5'(r), 32'h0, 4'h0);
            tick();
        end
        idle();
        #1;
        check_eq("drain_cnt", 32'(pend_cnt), 32'd0);
        drive_wr(5'd1, 32'h0, 4'h0);
        tick();
        idle();
        set_rd(0, 5'd1);
        #1;
        check_eq("redundant_wb_cnt", 32'(pend_cnt), 32'd0);
        check_eq("redundant_wb_busy", 32'(rd_busy[0]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised multi-port general-purpose register file for the multicycle CPU datapath.
- Generalised in data width, register count and number of read ports; adds per-byte write strobes and optional same-cycle write-to-read bypass.
- Adds a busy-bit scoreboard: the control unit marks a destination pending at issue, and writeback clears it. Hazard detection can stall on busy sources.
- Register 0 is hardwired to zero and is never busy.

Parameters:
- DATA_W, 32, register width in bits; must be a multiple of 8.
- ADDR_W, 5, address width; register count is 2**ADDR_W.
- NUM_RD, 2, number of independent read ports (1..4).
- BYPASS, 1, 1 = a read of the register being written this cycle returns the merged new value; 0 = returns the stored value.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset; asynchronous, active-high.
- RdAddr  in  NUM_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- RdData  out  NUM_RD*DATA_W  packed read data, combinational from RdAddr.
- RdBusy  out  NUM_RD  per-port busy flag of the addressed register.
- RegWre  in  1  write enable.
- WrAddr  in  ADDR_W  write address.
- WrData  in  DATA_W  write data.
- WrStrb  in  DATA_W/8  byte strobes; bit b enables byte b.
- IssueEn  in  1  mark IssueAddr busy.
- IssueAddr  in  ADDR_W  destination being issued.
- PendingCnt  out  ADDR_W+1  number of registers currently busy.

Behaviour:
- Reset (RST=1, asynchronous):
  - All registers clear to 0, all busy bits clear, PendingCnt=0.
  - Reset asserted mid-operation discards any in-flight write or issue.
  - Outputs are valid combinationally from the cleared state.
- Read:
  - RdData[k] = 0 when address is 0; otherwise register contents.
  - If BYPASS=1 and RegWre=1 and WrAddr==RdAddr[k]!=0, RdData[k] = stored value with the strobed bytes replaced by WrData bytes.
  - RdBusy[k] reflects the current busy bit and is not bypassed by a same-cycle issue or clear.
- Write, at the rising edge when RegWre=1 and WrAddr!=0:
  - Each byte b with WrStrb[b]=1 is updated; other bytes hold.
  - WrStrb=0 updates no bytes but still clears busy.
  - Writes to address 0 are ignored entirely.
- Scoreboard, per register r!=0, at each edge:
  - set = IssueEn && IssueAddr==r
  - clr = RegWre && WrAddr==r
  - busy_next = set ? 1 : (clr ? 0 : busy). Issue wins over simultaneous writeback to the same register, because it is a new producer.
  - Issue to an already-busy register: stays busy, no count change.
  - Writeback to a non-busy register: a plain write, no count change.
  - Issue or write to address 0 has no scoreboard effect.
- PendingCnt:
  - Registered.
  - Updated each edge by +1 for a 0→1 transition and −1 for a 1→0 transition.
  - Issue and clear on different registers in the same cycle give a net 0.
  - Range 0..2**ADDR_W−1; it can never wrap because register 0 is excluded.
- Latency:
  - Read: 0 cycles, combinational.
  - Write visible to a non-bypassed read: 1 cycle.
  - Busy: visible the cycle after issue.

Decomposition:
- Package reg_file_pkg:
  - DATA_W/ADDR_W defaults.
  - Strobe-merge function merge_bytes(old, new, strb).
  - Localparam NUM_REGS.
- Sub-module reg_scoreboard:
  - Contains the busy-bit vector, set/clear priority and the PendingCnt up/down counter.
  - Ports: CLK, RST, IssueEn, IssueAddr, ClrEn, ClrAddr, RdAddr, RdBusy, PendingCnt.
- The top level holds the storage array, the read muxes and the bypass logic.

Test Plan:
- Reset: pulse RST asynchronously mid-cycle after writing 0xDEADBEEF to r5 → RdData for r5 = 0 immediately, RdBusy=0, PendingCnt=0.
- Byte strobes: write r3=0x11223344 with WrStrb=4'hF, then WrData=0xAABBCCDD with WrStrb=4'b0101 → r3 = 0x11BB33DD; a write of 0xFFFFFFFF to r0 → r0 still reads 0.
- Bypass: with BYPASS=1, hold RdAddr[0]=r7 while writing 0x12345678 with all strobes → RdData same cycle = 0x12345678; with BYPASS=0 → old value this cycle, new value next cycle.
- Scoreboard:
  - Issue r4, then r9 → PendingCnt 1, then 2; RdBusy set for r4.
  - Writeback r4 → count 1.
  - Issue r9 together with writeback r9 → r9 stays busy, count stays 1.
- Concurrency: issue r2 and writeback r9 in the same cycle → r2 busy, r9 clear, PendingCnt unchanged; issue r0 → no change.
- Fill: issue r1..r31 on consecutive cycles → PendingCnt=31; write back all → 0, with no underflow on a redundant writeback.
